recepcao_comandos_servo: RTL and testbench

Frame parser that sits directly downstream of the 7E1 serial receiver and feeds the three servo controllers. It consumes received ASCII bytes plus the receiver's pronto pulse and recognises frames of the form '#' d1 d2 d3, where each d is '0'..'3'. On a valid frame it updates all three 2-bit servo positions atomically. Bad frames are rejected and counted.

---
 rtl/recepcao_comandos_servo.sv | 160 ++++++++++++++++
 tb/tb_recepcao_comandos_servo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/recepcao_comandos_servo.sv
// Frame parser between the 7E1 receiver and the three servo controllers: "#d1d2d3" sets all positions at once.
// Define CHECKSUM_EN to require a fifth char '0' + ((d1+d2+d3) mod 4) before the positions are loaded.
module recepcao_comandos_servo #(
  parameter int         TIMEOUT_CICLOS = 1_000_000,
  parameter int         N_TIMEOUT      = 20,
  parameter logic [6:0] CABECALHO      = 7'h23
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] dado_rx,
  input  logic       pronto_rx,
  output logic [1:0] posicao1,
  output logic [1:0] posicao2,
  output logic [1:0] posicao3,
  output logic       novo_frame,
  output logic       erro_frame,
  output logic       ocupado,
  output logic [2:0] db_estado,
  output logic [7:0] db_cont_erros
);

  typedef enum logic [2:0] {
    ESPERA_CAB = 3'd0,
    ESPERA_D1  = 3'd1,
    ESPERA_D2  = 3'd2,
    ESPERA_D3  = 3'd3,
    ATUALIZA   = 3'd4,
    ERRO       = 3'd5,
    ESPERA_CS  = 3'd6
  } estado_t;

  localparam logic [N_TIMEOUT-1:0] LIMITE_TIMEOUT = N_TIMEOUT'(TIMEOUT_CICLOS - 1);

  estado_t              estado_q;
  logic [1:0]           s1_q, s2_q;
  logic [1:0]           pos1_q, pos2_q, pos3_q;
  logic                 novo_q, erro_q;
  logic [7:0]           cont_erros_q, cont_erros_d;
  logic [N_TIMEOUT-1:0] timer_q;
  logic                 eh_cab, eh_digito, timeout_hit;
  logic [1:0]           valor;
`ifdef CHECKSUM_EN
  logic [1:0]           s3_q;
  logic [1:0]           cs_esperado;
  assign cs_esperado = s1_q + s2_q + s3_q;
`endif

  assign eh_cab       = (dado_rx == CABECALHO);
  assign eh_digito    = (dado_rx[6:2] == 5'b01100);
  assign valor        = dado_rx[1:0];
  assign timeout_hit  = (timer_q == LIMITE_TIMEOUT);
  assign cont_erros_d = (cont_erros_q == 8'hFF) ? cont_erros_q : cont_erros_q + 8'd1;

  // Every rejection (bad char, timeout or resync header) bumps the error count on the edge it is detected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q     <= ESPERA_CAB;
      s1_q         <= 2'b00;
      s2_q         <= 2'b00;
`ifdef CHECKSUM_EN
      s3_q         <= 2'b00;
`endif
      pos1_q       <= 2'b00;
      pos2_q       <= 2'b00;
      pos3_q       <= 2'b00;
      novo_q       <= 1'b0;
      erro_q       <= 1'b0;
      cont_erros_q <= 8'd0;
      timer_q      <= '0;
    end else begin
      novo_q <= 1'b0;
      erro_q <= 1'b0;
      case (estado_q)
`ifdef CHECKSUM_EN
        ESPERA_D1, ESPERA_D2, ESPERA_D3, ESPERA_CS: begin
`else
        ESPERA_D1, ESPERA_D2, ESPERA_D3: begin
`endif
          if (pronto_rx) begin
            timer_q <= '0;
            if (eh_cab) begin
              estado_q     <= ESPERA_D1;
              erro_q       <= 1'b1;
              cont_erros_q <= cont_erros_d;
            end else if (!eh_digito) begin
              estado_q     <= ERRO;
              erro_q       <= 1'b1;
              cont_erros_q <= cont_erros_d;
            end else begin
              case (estado_q)
                ESPERA_D1: begin
                  s1_q     <= valor;
                  estado_q <= ESPERA_D2;
                end
                ESPERA_D2: begin
                  s2_q     <= valor;
                  estado_q <= ESPERA_D3;
                end
`ifdef CHECKSUM_EN
                ESPERA_D3: begin
                  s3_q     <= valor;
                  estado_q <= ESPERA_CS;
                end
                default: begin
                  if (valor == cs_esperado) begin
                    pos1_q   <= s1_q;
                    pos2_q   <= s2_q;
                    pos3_q   <= s3_q;
                    novo_q   <= 1'b1;
                    estado_q <= ATUALIZA;
                  end else begin
                    estado_q     <= ERRO;
                    erro_q       <= 1'b1;
                    cont_erros_q <= cont_erros_d;
                  end
                end
`else
                default: begin
                  pos1_q   <= s1_q;
                  pos2_q   <= s2_q;
                  pos3_q   <= valor;
                  novo_q   <= 1'b1;
                  estado_q <= ATUALIZA;
                end
`endif
              endcase
            end
          end else if (timeout_hit) begin
            timer_q      <= '0;
            estado_q     <= ERRO;
            erro_q       <= 1'b1;
            cont_erros_q <= cont_erros_d;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        // Idle, ATUALIZA and ERRO (and any illegal code) only react to a header.
        default: begin
          timer_q <= '0;
          if (pronto_rx && eh_cab) begin
            estado_q <= ESPERA_D1;
          end else begin
            estado_q <= ESPERA_CAB;
          end
        end
      endcase
    end
  end

  assign posicao1      = pos1_q;
  assign posicao2      = pos2_q;
  assign posicao3      = pos3_q;
  assign novo_frame    = novo_q;
  assign erro_frame    = erro_q;
  assign db_estado     = estado_q;
  assign db_cont_erros = cont_erros_q;
  assign ocupado       = (estado_q == ESPERA_D1) || (estado_q == ESPERA_D2) ||
                         (estado_q == ESPERA_D3) || (estado_q == ESPERA_CS);

endmodule

// File: tb/tb_recepcao_comandos_servo.sv
// Directed bench for recepcao_comandos_servo with a short timeout; handles the CHECKSUM_EN build too.
module tb_recepcao_comandos_servo;

  localparam int T    = 40;
  localparam logic [6:0] HASH = 7'h23;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] dado_rx;
  logic       pronto_rx;
  logic [1:0] posicao1, posicao2, posicao3;
  logic       novo_frame, erro_frame, ocupado;
  logic [2:0] db_estado;
  logic [7:0] db_cont_erros;

  int nCompared   = 0;
  int nMismatched = 0;

  recepcao_comandos_servo #(
    .TIMEOUT_CICLOS(T),
    .N_TIMEOUT(20),
    .CABECALHO(7'h23)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dado_rx(dado_rx),
    .pronto_rx(pronto_rx),
    .posicao1(posicao1),
    .posicao2(posicao2),
    .posicao3(posicao3),
    .novo_frame(novo_frame),
    .erro_frame(erro_frame),
    .ocupado(ocupado),
    .db_estado(db_estado),
    .db_cont_erros(db_cont_erros)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] posCode(input int a, input int b, input int c);
    return 32'(a * 16 + b * 4 + c);
  endfunction

  function automatic logic [31:0] posNow();
    return 32'({posicao1, posicao2, posicao3});
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Waits gap idle cycles, then presents one byte for exactly one posedge; returns on the following negedge.
  task automatic applyStimulus(input logic [6:0] b, input int gap);
    repeat (gap) @(negedge clock);
    dado_rx   = b;
    pronto_rx = 1'b1;
    @(negedge clock);
    pronto_rx = 1'b0;
  endtask

  task automatic sendTail(input int d1, input int d2, input int d3, input int gap);
    applyStimulus(7'h30 + 7'(d1), gap);
    applyStimulus(7'h30 + 7'(d2), gap);
    applyStimulus(7'h30 + 7'(d3), gap);
`ifdef CHECKSUM_EN
    applyStimulus(7'h30 + 7'((d1 + d2 + d3) % 4), gap);
`endif
  endtask

  task automatic sendFrame(input int d1, input int d2, input int d3, input int gap);
    applyStimulus(HASH, gap);
    sendTail(d1, d2, d3, gap);
  endtask

  initial begin
    int waited;
    reset     = 1'b1;
    dado_rx   = 7'h00;
    pronto_rx = 1'b0;
    #12;
    checkOutput("rst_estado", 32'(db_estado), 0);
    checkOutput("rst_pos", posNow(), 0);
    checkOutput("rst_flags", 32'({novo_frame, erro_frame, ocupado}), 0);
    checkOutput("rst_cont", 32'(db_cont_erros), 0);
    @(negedge clock);
    reset = 1'b0;

    // Non-header bytes while idle are ignored silently
    applyStimulus(7'h78, 2);
    checkOutput("idle_estado", 32'(db_estado), 0);
    checkOutput("idle_cont", 32'(db_cont_erros), 0);

    // "#123", bytes 10 cycles apart
    sendFrame(1, 2, 3, 9);
    checkOutput("f123_novo", 32'(novo_frame), 1);
    checkOutput("f123_pos", posNow(), posCode(1, 2, 3));
    checkOutput("f123_estado", 32'(db_estado), 4);
    checkOutput("f123_cont", 32'(db_cont_erros), 0);
    @(negedge clock);
    checkOutput("f123_novo_off", 32'(novo_frame), 0);
    checkOutput("f123_estado_off", 32'(db_estado), 0);

    // "#1A" -> bad char error
    applyStimulus(HASH, 2);
    checkOutput("d1_ocupado", 32'(ocupado), 1);
    checkOutput("d1_estado", 32'(db_estado), 1);
    applyStimulus(7'h31, 2);
    applyStimulus(7'h41, 2);
    checkOutput("bad_erro", 32'(erro_frame), 1);
    checkOutput("bad_estado", 32'(db_estado), 5);
    checkOutput("bad_cont", 32'(db_cont_erros), 1);
    checkOutput("bad_pos", posNow(), posCode(1, 2, 3));
    @(negedge clock);
    checkOutput("bad_erro_off", 32'(erro_frame), 0);
    checkOutput("bad_estado_off", 32'(db_estado), 0);

    // '4' just above the valid range
    applyStimulus(HASH, 1);
    applyStimulus(7'h34, 1);
    checkOutput("char4_erro", 32'(erro_frame), 1);
    checkOutput("char4_cont", 32'(db_cont_erros), 2);

    // "#1#231" resync
    applyStimulus(HASH, 2);
    applyStimulus(7'h31, 2);
    applyStimulus(HASH, 2);
    checkOutput("resync_erro", 32'(erro_frame), 1);
    checkOutput("resync_estado", 32'(db_estado), 1);
    checkOutput("resync_cont", 32'(db_cont_erros), 3);
    sendTail(2, 3, 1, 2);
    checkOutput("resync_novo", 32'(novo_frame), 1);
    checkOutput("resync_pos", posNow(), posCode(2, 3, 1));
    checkOutput("resync_cont2", 32'(db_cont_erros), 3);

    // "#2" then idle until timeout
    applyStimulus(HASH, 2);
    applyStimulus(7'h32, 2);
    waited = 0;
    while (erro_frame !== 1'b1 && waited < T + 20) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("tmo_cycles", 32'(waited), 32'(T));
    checkOutput("tmo_estado", 32'(db_estado), 5);
    checkOutput("tmo_cont", 32'(db_cont_erros), 4);
    checkOutput("tmo_pos", posNow(), posCode(2, 3, 1));
    @(negedge clock);
    checkOutput("tmo_estado_off", 32'(db_estado), 0);
    sendFrame(0, 0, 0, 1);
    checkOutput("f000_pos", posNow(), posCode(0, 0, 0));

    // Header arriving during ATUALIZA starts a new frame
    sendFrame(3, 3, 3, 1);
    checkOutput("f333_pos", posNow(), posCode(3, 3, 3));
    applyStimulus(HASH, 0);
    checkOutput("atu_hdr_estado", 32'(db_estado), 1);
    sendTail(2, 2, 2, 0);
    checkOutput("f222_novo", 32'(novo_frame), 1);
    checkOutput("f222_pos", posNow(), posCode(2, 2, 2));

    // Asynchronous reset while in ESPERA_D2
    applyStimulus(HASH, 1);
    applyStimulus(7'h33, 1);
    checkOutput("pre_rst_estado", 32'(db_estado), 2);
    #1 reset = 1'b1;
    #1;
    checkOutput("arst_estado", 32'(db_estado), 0);
    checkOutput("arst_pos", posNow(), 0);
    checkOutput("arst_flags", 32'({novo_frame, erro_frame, ocupado}), 0);
    checkOutput("arst_cont", 32'(db_cont_erros), 0);
    @(negedge clock);
    reset = 1'b0;
    sendFrame(3, 2, 1, 1);
    checkOutput("f321_pos", posNow(), posCode(3, 2, 1));
    checkOutput("f321_novo", 32'(novo_frame), 1);

`ifdef CHECKSUM_EN
    applyStimulus(HASH, 1);
    applyStimulus(7'h31, 1);
    applyStimulus(7'h32, 1);
    applyStimulus(7'h33, 1);
    applyStimulus(7'h32, 1);
    checkOutput("cs_ok_pos", posNow(), posCode(1, 2, 3));
    checkOutput("cs_ok_novo", 32'(novo_frame), 1);
    applyStimulus(HASH, 1);
    applyStimulus(7'h33, 1);
    applyStimulus(7'h33, 1);
    applyStimulus(7'h33, 1);
    applyStimulus(7'h30, 1);
    checkOutput("cs_bad_erro", 32'(erro_frame), 1);
    checkOutput("cs_bad_pos", posNow(), posCode(1, 2, 3));
`endif

    // 256 bad frames saturate the counter
    for (int i = 0; i < 256; i++) begin
      applyStimulus(HASH, 0);
      applyStimulus(7'h41, 0);
    end
    checkOutput("sat_cont", 32'(db_cont_erros), 255);
    applyStimulus(HASH, 0);
    applyStimulus(7'h41, 0);
    checkOutput("sat_erro", 32'(erro_frame), 1);
    checkOutput("sat_hold", 32'(db_cont_erros), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
